// File: rtl/wb_arb_pkg.sv
// Shared types, protected-register constants and helpers for the register-file write arbiter.
package wb_arb_pkg;

  typedef logic [4:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_K0   = 5'd26;
  localparam reg_addr_t REG_K1   = 5'd27;

  // Bits 0, 26 and 27: registers that can never be written or marked busy.
  localparam logic [31:0] PROTECTED_MASK = 32'h0C00_0001;

  typedef struct packed {
    reg_addr_t   addr;
    logic [31:0] data;
  } wb_entry_t;

  function automatic logic is_writable(input reg_addr_t addr);
    return (addr != REG_ZERO) && (addr != REG_K0) && (addr != REG_K1);
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Valid/ready handshake carrying long-latency (secondary) writeback results.
interface regfile_write_arbiter_if;
  import wb_arb_pkg::*;

  logic        L_Valid;
  logic        L_Ready;
  reg_addr_t   L_WAddr;
  logic [31:0] L_WData;

  modport master (output L_Valid, output L_WAddr, output L_WData, input L_Ready);
  modport slave  (input L_Valid, input L_WAddr, input L_WData, output L_Ready);

endinterface

// File: rtl/wb_arb_fifo.sv
// In-order FIFO of pending secondary writes; wrap-bit pointers separate full from empty.
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  wb_entry_t   mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges pipeline writeback (primary) and buffered long-latency results onto the single
// register-file write port. Define WBARB_BYPASS_EN to let an idle cycle take a secondary beat directly.
module regfile_write_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    P_RegWrite,
  input  reg_addr_t               P_WAddr,
  input  logic [31:0]             P_WData,
  regfile_write_arbiter_if.slave  sec,
  input  logic                    Iss_Valid,
  input  reg_addr_t               Iss_WAddr,
  output logic [31:0]             Busy,
  output logic                    Stall_Req,
  output reg_addr_t               WAddr,
  output logic [31:0]             WData,
  output logic                    RegWrite
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic             fifo_full;
  logic             fifo_empty;
  wb_entry_t        head;
  logic             p_ok;
  logic             l_ok;
  logic             bypass;
  logic             push;
  logic             pop;
  logic [31:0]      busy_next;
  logic [CNT_W-1:0] starve_q;

  assign sec.L_Ready = !fifo_full;
  assign p_ok        = P_RegWrite && is_writable(P_WAddr);
  // Protected secondary beats still handshake; they are simply never stored.
  assign l_ok        = sec.L_Valid && sec.L_Ready && is_writable(sec.L_WAddr);

`ifdef WBARB_BYPASS_EN
  assign bypass = l_ok && fifo_empty && !p_ok;
`else
  assign bypass = 1'b0;
`endif

  assign push = l_ok && !bypass;
  assign pop  = !p_ok && !fifo_empty;

  wb_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (Clk),
    .rst_n      (Rst_n),
    .push       (push),
    .push_entry ('{addr: sec.L_WAddr, data: sec.L_WData}),
    .pop        (pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Clears are applied before the issue set so a same-cycle set wins.
  always_comb begin
    busy_next = Busy;
    if (pop)    busy_next[head.addr]    = 1'b0;
    if (bypass) busy_next[sec.L_WAddr]  = 1'b0;
    if (Iss_Valid && is_writable(Iss_WAddr)) busy_next[Iss_WAddr] = 1'b1;
    busy_next = busy_next & ~PROTECTED_MASK;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      WAddr     <= '0;
      WData     <= '0;
      RegWrite  <= 1'b0;
      Busy      <= '0;
      Stall_Req <= 1'b0;
      starve_q  <= '0;
    end else begin
      Busy <= busy_next;

      if (p_ok) begin
        RegWrite <= 1'b1;
        WAddr    <= P_WAddr;
        WData    <= P_WData;
      end else if (pop) begin
        RegWrite <= 1'b1;
        WAddr    <= head.addr;
        WData    <= head.data;
      end else if (bypass) begin
        RegWrite <= 1'b1;
        WAddr    <= sec.L_WAddr;
        WData    <= sec.L_WData;
      end else begin
        RegWrite <= 1'b0;
      end

      Stall_Req <= (starve_q == LIMIT);

      if (fifo_empty || pop)   starve_q <= '0;
      else if (starve_q != LIMIT) starve_q <= starve_q + CNT_W'(1);
    end
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Sits directly upstream of the register file's single write port (WAddr/WData/RegWrite).
- Merges two write sources:
  - the in-order pipeline writeback (primary, never back-pressured);
  - a long-latency source such as a mult/div unit (secondary, buffered, valid/ready).
- Keeps a per-register pending scoreboard for the hazard unit, and raises a stall request when the secondary source is starved.

Parameters:
- DEPTH, 2: secondary FIFO entries (power of 2, ≥2).
- STARVE_LIMIT, 4: consecutive blocked cycles of a non-empty FIFO before Stall_Req rises.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Rst_n  in  1  asynchronous active-low reset.
- P_RegWrite  in  1  primary write request.
- P_WAddr  in  5  primary destination register.
- P_WData  in  32  primary write data.
- L_Valid  in  1  secondary result valid.
- L_Ready  out  1  secondary accept; equals not FIFO full.
- L_WAddr  in  5  secondary destination register.
- L_WData  in  32  secondary write data.
- Iss_Valid  in  1  long-latency op issued this cycle.
- Iss_WAddr  in  5  destination of the issued op.
- Busy  out  32  scoreboard; bit r set means r has an outstanding secondary write.
- Stall_Req  out  1  request a pipeline bubble so the FIFO can drain.
- WAddr  out  5  to register file.
- WData  out  32  to register file.
- RegWrite  out  1  to register file.

Behaviour:
- Reset (async, Rst_n=0): WAddr=0, WData=0, RegWrite=0, Busy=0, Stall_Req=0, FIFO emptied, starve counter=0. Reset mid-operation discards all queued entries; nothing is written afterwards.
- Protected addresses are 0, 26 and 27.
  - A request to a protected address is dropped: no RegWrite and no FIFO entry. A dropped secondary beat is still handshaken.
  - A dropped primary request counts as primary idle.
- Output stage is registered. Each cycle exactly one of:
  - a primary grant;
  - a FIFO-head grant;
  - idle, which drives RegWrite=0 and holds WAddr/WData.
- Priority: valid primary (P_RegWrite=1, unprotected address) always wins and appears on the outputs at the next edge (latency 1).
- FIFO head is granted only when the primary is idle. Grant pops the head.
- Secondary handshake:
  - A beat transfers on a posedge with L_Valid and L_Ready both high.
  - L_Ready is combinational from full only.
  - Enqueue and pop in the same cycle on a full FIFO is not allowed: L_Ready is already 0.
  - Pop and enqueue on a non-full FIFO are both allowed in one cycle.
  - Minimum latency from enqueue edge to RegWrite is 2 edges.
- Ordering: FIFO is strict in-order. Pointers wrap modulo DEPTH; one extra wrap bit distinguishes full from empty.
- Scoreboard:
  - Iss_Valid sets Busy[Iss_WAddr], except for protected addresses.
  - A FIFO-head grant clears Busy[head addr].
  - Set and clear of the same bit in one cycle: set wins.
  - Busy[0], Busy[26] and Busy[27] are constant 0.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and the primary wins.
  - Resets to 0 on any FIFO grant or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
  - Stall_Req is registered: high the cycle after the counter reaches STARVE_LIMIT, and drops the cycle after the FIFO head is granted.
- Primary writes to a Busy register are performed unchanged; WAW avoidance belongs to the hazard unit.

Optional Feature:
- Macro: WBARB_BYPASS_EN.
- Defined: when the FIFO is empty, the primary is idle and a secondary beat is accepted, the beat is written directly to the output stage at that edge (latency 1). No FIFO entry is made, and Busy for that address is cleared at that edge.
- Undefined: every secondary beat passes through the FIFO (latency ≥2).

Decomposition:
- Shared package wb_arb_pkg holds:
  - constants REG_ZERO=0, REG_K0=26, REG_K1=27;
  - a reg_addr_t 5-bit type;
  - function is_writable(addr).
- One sub-module, wb_arb_fifo: the parameterised DEPTH FIFO with push/pop/full/empty, holding address+data.

Test Plan:
- Reset, then P_RegWrite=1, P_WAddr=5, P_WData=0x1234 → next cycle RegWrite=1, WAddr=5, WData=0x1234; P_WAddr=0 or 26 → RegWrite stays 0.
- Iss_Valid with Iss_WAddr=8 → Busy[8]=1. Then L beat (8, 0xDEAD) with primary idle → RegWrite with (8, 0xDEAD) 2 edges later (1 with WBARB_BYPASS_EN), and Busy[8]=0 after that grant.
- Primary active every cycle, push L beats to regs 9 and 10 → L_Ready=0 after 2 accepts; Stall_Req=1 after 4 blocked cycles. Drop primary → 9 then 10 written in order, then Stall_Req=0.
- Same-cycle Iss_Valid(12) and FIFO-head grant for reg 12 → Busy[12] remains 1.
- Fill FIFO with 2 entries, assert Rst_n=0 mid-drain → immediate RegWrite=0, Busy=0, L_Ready=1; no queued write appears after release.
- L beat to reg 27 → handshake completes, no RegWrite, FIFO count unchanged.
